// File: rtl/pong_pkg.sv
// pong_pkg: state encoding, default build constants and winner encoding shared across the pong design
package pong_pkg;
  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;
  localparam int DEF_WIN_SCORE = 7;
  localparam int DEF_PAUSE_CYCLES = 25_000_000;
  localparam logic WINNER_P1 = 1'b0;
  localparam logic WINNER_P2 = 1'b1;
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: miss events in, scores and game status out
interface score_keeper_if #(parameter int SCORE_W = 4);
  logic miss_left;
  logic miss_right;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic point_p1;
  logic point_p2;
  logic serve_en;
  logic game_end;
  logic winner;
  modport master (
    output miss_left, miss_right,
    input score_p1, score_p2, point_p1, point_p2, serve_en, game_end, winner
  );
  modport slave (
    input miss_left, miss_right,
    output score_p1, score_p2, point_p1, point_p2, serve_en, game_end, winner
  );
endinterface

// File: rtl/pause_timer.sv
// pause_timer: loadable down-counter that idles at zero and flags done there
module pause_timer #(
  parameter int PAUSE_W = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PAUSE_W-1:0] load_val,
  output logic               done
);
  logic [PAUSE_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done = cnt_q == '0;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: scores ball misses, sequences serve pauses and declares the winner
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = DEF_WIN_SCORE,
  parameter int SCORE_W = 4,
  parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES,
  parameter int PAUSE_W = 25
) (
  input logic clk,
  input logic rst_n,
  score_keeper_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic p1_q, p1_d, p2_q, p2_d;
  logic winner_q, winner_d;
  logic serve_en_q, serve_en_d;
  logic game_end_q, game_end_d;
  logic in_play, miss_any, hit_p1, hit_p2, win1, win2, done;
  assign in_play = state_q == ST_PLAY;
  assign miss_any = bus.miss_left | bus.miss_right;
  assign hit_p1 = in_play & bus.miss_right & ~bus.miss_left;
  assign hit_p2 = in_play & bus.miss_left & ~bus.miss_right;
  pause_timer #(.PAUSE_W(PAUSE_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(in_play & miss_any),
    .load_val(PAUSE_W'(PAUSE_CYCLES - 1)),
    .done(done)
  );
  always_comb begin
    s1_d = hit_p1 ? s1_q + 1'b1 : s1_q;
    s2_d = hit_p2 ? s2_q + 1'b1 : s2_q;
    p1_d = hit_p1;
    p2_d = hit_p2;
    win1 = hit_p1 && s1_d == SCORE_W'(WIN_SCORE);
    win2 = hit_p2 && s2_d == SCORE_W'(WIN_SCORE);
    state_d = (win1 || win2) ? ST_OVER :
              (in_play && miss_any) ? ST_PAUSE :
              (state_q == ST_PAUSE && done) ? ST_PLAY : state_q;
    winner_d = win1 ? WINNER_P1 : win2 ? WINNER_P2 : winner_q;
    serve_en_d = state_d == ST_PLAY;
    game_end_d = state_d == ST_OVER;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_PLAY;
      s1_q <= '0;
      s2_q <= '0;
      p1_q <= 1'b0;
      p2_q <= 1'b0;
      winner_q <= WINNER_P1;
      serve_en_q <= 1'b1;
      game_end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      winner_q <= winner_d;
      serve_en_q <= serve_en_d;
      game_end_q <= game_end_d;
    end
  end
  assign bus.score_p1 = s1_q;
  assign bus.score_p2 = s2_q;
  assign bus.point_p1 = p1_q;
  assign bus.point_p2 = p2_q;
  assign bus.winner = winner_q;
  assign bus.serve_en = serve_en_q;
  assign bus.game_end = game_end_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed and random miss/reset stimulus against a game-rules reference model
module tb_score_keeper;
  localparam int WIN = 3;
  localparam int PC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int m_s1, m_s2, m_pause_left;
  bit m_over, m_winner, m_pt1, m_pt2;
  score_keeper_if #(.SCORE_W(4)) bus ();
  score_keeper #(.WIN_SCORE(WIN), .SCORE_W(4), .PAUSE_CYCLES(PC), .PAUSE_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input bit ml, input bit mr, input bit rn);
    m_pt1 = 0;
    m_pt2 = 0;
    if (!rn) begin
      m_s1 = 0; m_s2 = 0; m_pause_left = 0; m_over = 0; m_winner = 0;
    end else if (m_over) begin
    end else if (m_pause_left > 0) begin
      m_pause_left--;
    end else if (ml && mr) begin
      m_pause_left = PC;
    end else if (ml || mr) begin
      if (mr) begin m_s1++; m_pt1 = 1; end
      else begin m_s2++; m_pt2 = 1; end
      if (m_s1 == WIN || m_s2 == WIN) begin
        m_over = 1;
        m_winner = (m_s2 == WIN);
      end else m_pause_left = PC;
    end
  endtask
  task automatic step(input bit ml, input bit mr, input bit rn);
    @(negedge clk);
    bus.miss_left = ml;
    bus.miss_right = mr;
    rst_n = rn;
    @(posedge clk);
    model(ml, mr, rn);
    #1;
    chk("score_p1", 32'(bus.score_p1), 32'(m_s1));
    chk("score_p2", 32'(bus.score_p2), 32'(m_s2));
    chk("point_p1", 32'(bus.point_p1), 32'(m_pt1));
    chk("point_p2", 32'(bus.point_p2), 32'(m_pt2));
    chk("serve_en", 32'(bus.serve_en), 32'(!m_over && m_pause_left == 0));
    chk("game_end", 32'(bus.game_end), 32'(m_over));
    if (m_over) chk("winner", 32'(bus.winner), 32'(m_winner));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask
  initial begin
    bus.miss_left = 0;
    bus.miss_right = 0;
    step(0, 0, 0);
    chk("rst_serve", 32'(bus.serve_en), 32'd1);
    idle(2);
    step(0, 1, 1);
    chk("first_point", 32'(bus.score_p1), 32'd1);
    chk("first_pulse", 32'(bus.point_p1), 32'd1);
    idle(5);
    step(1, 1, 1);
    chk("dead_ball_serve", 32'(bus.serve_en), 32'd0);
    idle(5);
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    idle(3);
    chk("pause_ignored_p1", 32'(bus.score_p1), 32'd1);
    chk("pause_ignored_p2", 32'(bus.score_p2), 32'd1);
    step(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1);
      idle(4);
    end
    chk("over_p2", 32'(bus.score_p2), 32'd3);
    chk("over_end", 32'(bus.game_end), 32'd1);
    chk("over_winner", 32'(bus.winner), 32'd1);
    step(0, 1, 1);
    step(1, 0, 1);
    chk("over_frozen_p1", 32'(bus.score_p1), 32'd0);
    step(0, 0, 0);
    chk("restart_end", 32'(bus.game_end), 32'd0);
    step(0, 1, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("midpause_rst_p2", 32'(bus.score_p2), 32'd0);
    chk("midpause_rst_pt", 32'(bus.point_p2), 32'd0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 79) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
# score_keeper

Tracks both players' scores from ball-miss events and sequences serve pauses. Declares the game over when a player reaches the winning score. Sits directly upstream of the game reset logic: its `game_end` output is the term that, combined with the player's restart input, triggers the game-wide reset. It also gates ball motion through `serve_en`.

## Interface
- `WIN_SCORE`, 7, points needed to win; 1 ≤ WIN_SCORE ≤ 2^SCORE_W−1
- `SCORE_W`, 4, width of each score register
- `PAUSE_CYCLES`, 25_000_000, post-point hold length in clocks (0.5 s at 50 MHz); must be ≥ 1
- `PAUSE_W`, 25, pause counter width; 2^PAUSE_W > PAUSE_CYCLES
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  reset: one clock, synchronous, active-low
- `miss_left`  in  1  one-cycle pulse: ball passed the left paddle (point to P2)
- `miss_right`  in  1  one-cycle pulse: ball passed the right paddle (point to P1)
- `score_p1`  out  SCORE_W  left player score
- `score_p2`  out  SCORE_W  right player score
- `point_p1`, `point_p2`  out  1  one-cycle pulse when that player scores (sound/flash)
- `serve_en`  out  1  ball may move; high only in PLAY
- `game_end`  out  1  level; high in OVER until reset
- `winner`  out  1  0 = P1, 1 = P2; valid only while `game_end` = 1

## Operation
- States: PLAY, PAUSE, OVER.
- Reset (`rst_n` = 0 at an edge), from any state and including mid-pause: state ← PLAY, both scores ← 0, pause counter ← 0, `winner` ← 0.
- Output values after reset: `serve_en` = 1; `game_end`, `point_p1`, `point_p2` = 0.
- PLAY with exactly one miss pulse:
  - Increment the scorer's score.
  - Pulse that player's `point_*`.
  - If the new score equals WIN_SCORE: go to OVER and latch `winner`. Otherwise go to PAUSE with the counter loaded to PAUSE_CYCLES−1.
- PLAY with both miss pulses in the same cycle: dead ball. No score, no point pulse. Go to PAUSE.
- PLAY with no miss: stay in PLAY.
- PAUSE:
  - Counter decrements each cycle.
  - At 0, go to PLAY.
  - All miss inputs are ignored.
- OVER:
  - Scores, `winner` and `game_end` are frozen.
  - Miss inputs are ignored.
  - Only `rst_n` exits this state.
- Scores never exceed WIN_SCORE, so no wrap is possible.

## Timing
- All outputs are registered.
- A miss sampled at edge N gives the updated score, `point_*`, state and `serve_en` in the cycle after edge N.
- `point_*` is high for exactly one cycle.
- `serve_en` is low for exactly PAUSE_CYCLES cycles per PAUSE visit.
- `game_end` rises one cycle after the winning miss is sampled. It stays high until the first edge with `rst_n` = 0, and is 0 in the cycle after that edge.
- A miss coincident with `rst_n` = 0 is dropped; reset wins.
- A miss on the same edge as the PAUSE→PLAY transition is ignored. Misses count only when sampled while already in PLAY.

## Structure
- Shared package `pong_pkg` holds:
  - state encoding localparams (PLAY, PAUSE, OVER);
  - default WIN_SCORE and the PAUSE_CYCLES for the 50 MHz build;
  - the P1/P2 winner encoding, shared with display and reset logic.
- Sub-module `pause_timer`: loadable down-counter with a `done` flag.
  - Parameters: PAUSE_W.
  - Inputs: `load`, `load_val`.
  - Output: `done`.
- The FSM and score registers stay in `score_keeper`.

## Test plan
Bench parameters for all scenarios: WIN_SCORE = 3, PAUSE_CYCLES = 4.

- Reset, then single `miss_right` → one cycle later `score_p1` = 1 and `point_p1` pulses once; `serve_en` low 4 cycles, then high.
- `miss_left` and `miss_right` in the same cycle → scores stay 0/0, no point pulse, 4-cycle pause.
- Miss pulses during PAUSE → ignored; scores unchanged.
- Three `miss_left` events separated by pauses → `score_p2` = 3, `game_end` = 1, `winner` = 1, `serve_en` = 0. Further misses leave scores at 0/3.
- From OVER, drop `rst_n` for one cycle → scores 0/0, `game_end` = 0, `serve_en` = 1 in the next cycle.
- Reset asserted mid-pause with a miss on the same edge → PLAY, scores 0/0, no point pulse.
